// File: rtl/jelly_integer_accumulator_stream_pkg.sv
// Shared helpers for the streaming frame accumulator and its carry-segmented core.
package jelly_integer_accumulator_stream_pkg;

  // Operation requested from the accumulator core on an enabled cycle.
  typedef enum logic [1:0] {
    ACC_OP_HOLD = 2'd0,
    ACC_OP_SET  = 2'd1,
    ACC_OP_ADD  = 2'd2
  } acc_op_e;

  // Number of carry-chain segments needed to cover the accumulator width.
  function automatic int unit_num(input int acc_width, input int unit_width);
    return (acc_width + unit_width - 1) / unit_width;
  endfunction

endpackage

// File: rtl/jelly_integer_accumulator_stream_accumulator.sv
// Carry-segmented accumulator core. Each UNIT_WIDTH slice adds independently and
// parks its carry-out in a flop, so the critical path is one unit wide. Pending
// carries ripple up one unit per enabled cycle with set=add=0; busy stays high
// while any carry is still parked. Carry out of the top unit is dropped, so the
// sum wraps modulo 2^ACCUMULATOR_WIDTH.
module jelly_integer_accumulator
  import jelly_integer_accumulator_stream_pkg::*;
#(
  parameter int SIGEND            = 0,
  parameter int ACCUMULATOR_WIDTH = 64,
  parameter int DATA_WIDTH        = 32,
  parameter int UNIT_WIDTH        = 32
) (
  input  logic                         reset,
  input  logic                         clk,
  input  logic                         cke,
  input  logic                         set,
  input  logic                         add,
  input  logic [DATA_WIDTH-1:0]        data,
  output logic                         busy,
  output logic [ACCUMULATOR_WIDTH-1:0] accumulator
);

  localparam int UNIT_NUM  = unit_num(ACCUMULATOR_WIDTH, UNIT_WIDTH);
  localparam int EXT_WIDTH = UNIT_NUM * UNIT_WIDTH;

  logic [UNIT_NUM-1:0][UNIT_WIDTH-1:0] val_q;
  logic [UNIT_NUM-1:0][UNIT_WIDTH-1:0] val_d;
  logic [UNIT_NUM-1:0][UNIT_WIDTH-1:0] data_u;
  logic [UNIT_NUM-1:0]                 carry_q;
  logic [UNIT_NUM-1:0]                 carry_d;
  logic [UNIT_NUM-1:0]                 carry_in;
  logic [EXT_WIDTH-1:0]                data_ext;
  logic [EXT_WIDTH-1:0]                val_flat;
  logic [UNIT_WIDTH:0]                 sum;
  logic                                fill;

  // Widen the sample to the full segmented width (sign- or zero-extended).
  always_comb begin
    fill                     = (SIGEND != 0) ? data[DATA_WIDTH-1] : 1'b0;
    data_ext                 = {EXT_WIDTH{fill}};
    data_ext[DATA_WIDTH-1:0] = data;
    data_u                   = data_ext;
  end

  // Per-unit add: each unit takes the parked carry of the unit below it.
  always_comb begin
    carry_in = carry_q << 1;
    val_d    = val_q;
    carry_d  = '0;
    sum      = '0;
    if (set) begin
      val_d   = data_u;
      carry_d = '0;
    end else begin
      for (int i = 0; i < UNIT_NUM; i++) begin
        sum = {1'b0, val_q[i]}
            + (add ? {1'b0, data_u[i]} : {(UNIT_WIDTH+1){1'b0}})
            + {{UNIT_WIDTH{1'b0}}, carry_in[i]};
        val_d[i]   = sum[UNIT_WIDTH-1:0];
        carry_d[i] = sum[UNIT_WIDTH];
      end
      // Overflow out of the top unit is discarded.
      carry_d[UNIT_NUM-1] = 1'b0;
    end
  end

  // Segment and carry registers; synchronous reset, frozen when cke is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      val_q   <= '0;
      carry_q <= '0;
    end else if (cke) begin
      val_q   <= val_d;
      carry_q <= carry_d;
    end
  end

  assign val_flat    = val_q;
  assign accumulator = val_flat[ACCUMULATOR_WIDTH-1:0];
  assign busy        = |carry_q;

endmodule

// File: rtl/jelly_integer_accumulator_stream.sv
// Streaming frame accumulator: sums the beats of each s_first..s_last frame,
// waits for the segmented carries to settle, then presents the sum and beat
// count on the output handshake. Input is stalled while a result is pending.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no frame open; next accepted beat starts one
// ST_ACC   | frame open; beats add (s_first restarts the frame)
// ST_FLUSH | frame closed; ripple pending carries until core not busy
// ST_OUT   | m_valid high with stable sum/count until m_ready
module jelly_integer_accumulator_stream
  import jelly_integer_accumulator_stream_pkg::*;
#(
  parameter int SIGNED            = 0,
  parameter int ACCUMULATOR_WIDTH = 64,
  parameter int DATA_WIDTH        = 32,
  parameter int UNIT_WIDTH        = 32,
  parameter int COUNT_WIDTH       = 16
) (
  input  logic                         aresetn,
  input  logic                         aclk,
  input  logic                         aclken,
  input  logic                         s_first,
  input  logic                         s_last,
  input  logic [DATA_WIDTH-1:0]        s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [ACCUMULATOR_WIDTH-1:0] m_data,
  output logic [COUNT_WIDTH-1:0]       m_count,
  output logic                         m_valid,
  input  logic                         m_ready
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACC   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  logic [1:0]                   state_q;
  logic [1:0]                   state_d;
  logic [COUNT_WIDTH-1:0]       count_q;
  logic [COUNT_WIDTH-1:0]       count_d;
  logic                         accept;
  acc_op_e                      acc_op;
  logic                         acc_cke;
  logic                         acc_set;
  logic                         acc_add;
  logic                         acc_busy;
  logic                         acc_reset;
  logic [ACCUMULATOR_WIDTH-1:0] acc_value;

  // aresetn term keeps s_ready low asynchronously while reset is held.
  assign s_ready = aresetn & aclken & ((state_q == ST_IDLE) | (state_q == ST_ACC));
  assign accept  = s_valid & s_ready;

  // Next-state, beat counter and core operation selection.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_op  = ACC_OP_HOLD;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          acc_op  = ACC_OP_SET;
          count_d = COUNT_WIDTH'(1);
          state_d = s_last ? ST_FLUSH : ST_ACC;
        end
      end
      ST_ACC: begin
        if (accept) begin
          if (s_first) begin
            acc_op  = ACC_OP_SET;
            count_d = COUNT_WIDTH'(1);
          end else begin
            acc_op  = ACC_OP_ADD;
            count_d = count_q + COUNT_WIDTH'(1);
          end
          state_d = s_last ? ST_FLUSH : ST_ACC;
        end
      end
      ST_FLUSH: begin
        if (!acc_busy) begin
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers, advancing only on enabled cycles.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else if (aclken) begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign acc_set   = (acc_op == ACC_OP_SET);
  assign acc_add   = (acc_op == ACC_OP_ADD);
  assign acc_cke   = aclken & (accept | (state_q == ST_FLUSH));
  assign acc_reset = ~aresetn;

  jelly_integer_accumulator #(
    .SIGEND            (SIGNED),
    .ACCUMULATOR_WIDTH (ACCUMULATOR_WIDTH),
    .DATA_WIDTH        (DATA_WIDTH),
    .UNIT_WIDTH        (UNIT_WIDTH)
  ) u_accumulator (
    .reset       (acc_reset),
    .clk         (aclk),
    .cke         (acc_cke),
    .set         (acc_set),
    .add         (acc_add),
    .data        (s_data),
    .busy        (acc_busy),
    .accumulator (acc_value)
  );

  // Core is not clocked in ST_OUT, so its value is stable while m_valid waits.
  assign m_valid = (state_q == ST_OUT);
  assign m_data  = acc_value;
  assign m_count = count_q;

endmodule

// File: tb/tb_jelly_integer_accumulator_stream.sv
// Bench for the streaming frame accumulator: an unsigned and a signed instance
// see the same stimulus; expected frame results are queued at issue time and
// popped by per-instance monitors on each output transfer.
module tb_jelly_integer_accumulator_stream;

  logic        aclk    = 1'b0;
  logic        aresetn = 1'b0;
  logic        aclken  = 1'b1;
  logic        s_first = 1'b0;
  logic        s_last  = 1'b0;
  logic        s_valid = 1'b0;
  logic        m_ready = 1'b1;
  logic [31:0] s_data  = '0;

  logic        s_ready_u, s_ready_s, m_valid_u, m_valid_s;
  logic [63:0] m_data_u, m_data_s;
  logic [15:0] m_count_u, m_count_s;

  int n_checks = 0;
  int n_pass   = 0;
  bit toggle_en = 1'b0;

  typedef struct packed {
    logic [63:0] data;
    logic [15:0] count;
  } exp_t;

  exp_t q_u[$];
  exp_t q_s[$];

  always #5 aclk = ~aclk;

  jelly_integer_accumulator_stream #(
    .SIGNED(0), .ACCUMULATOR_WIDTH(64), .DATA_WIDTH(32), .UNIT_WIDTH(32), .COUNT_WIDTH(16)
  ) u_dut (
    .aresetn(aresetn), .aclk(aclk), .aclken(aclken),
    .s_first(s_first), .s_last(s_last), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_u),
    .m_data(m_data_u), .m_count(m_count_u), .m_valid(m_valid_u), .m_ready(m_ready)
  );

  jelly_integer_accumulator_stream #(
    .SIGNED(1), .ACCUMULATOR_WIDTH(64), .DATA_WIDTH(32), .UNIT_WIDTH(32), .COUNT_WIDTH(16)
  ) u_dut_s (
    .aresetn(aresetn), .aclk(aclk), .aclken(aclken),
    .s_first(s_first), .s_last(s_last), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_s),
    .m_data(m_data_s), .m_count(m_count_s), .m_valid(m_valid_s), .m_ready(m_ready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic push(input logic [63:0] du, input logic [63:0] ds, input logic [15:0] c);
    exp_t e;
    e.count = c;
    e.data  = du;
    q_u.push_back(e);
    e.data  = ds;
    q_s.push_back(e);
  endtask

  // Unsigned instance monitor.
  always @(negedge aclk) begin
    exp_t e;
    if (aresetn && aclken && m_valid_u && m_ready) begin
      if (q_u.size() == 0) begin
        n_checks++;
        $display("FAIL u_extra_beat: got data %h count %0d, expected no output", m_data_u, m_count_u);
      end else begin
        e = q_u.pop_front();
        check("u_data", m_data_u, e.data);
        check("u_count", {48'b0, m_count_u}, {48'b0, e.count});
      end
    end
  end

  // Signed instance monitor.
  always @(negedge aclk) begin
    exp_t e;
    if (aresetn && aclken && m_valid_s && m_ready) begin
      if (q_s.size() == 0) begin
        n_checks++;
        $display("FAIL s_extra_beat: got data %h count %0d, expected no output", m_data_s, m_count_s);
      end else begin
        e = q_s.pop_front();
        check("s_data", m_data_s, e.data);
        check("s_count", {48'b0, m_count_s}, {48'b0, e.count});
      end
    end
  end

  // Clock-enable driver: random when toggling is enabled, otherwise held high.
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      aclken = toggle_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic f, input logic l);
    int guard;
    guard   = 0;
    s_data  = d;
    s_first = f;
    s_last  = l;
    s_valid = 1'b1;
    @(negedge aclk);
    while (!s_ready_u && guard < 200) begin
      guard++;
      @(negedge aclk);
    end
    if (!s_ready_u) timeout_fail("send_beat");
    else @(posedge aclk);
    #1;
    s_valid = 1'b0;
    s_first = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((q_u.size() != 0 || q_s.size() != 0) && guard < 300) begin
      guard++;
      @(negedge aclk);
    end
    if (q_u.size() != 0 || q_s.size() != 0) timeout_fail("wait_drain");
    @(posedge aclk);
    #1;
  endtask

  // Called just after the s_last handshake edge. Latency counts that edge as
  // cycle 1 and the edge that raises m_valid as the last counted cycle.
  task automatic measure_latency(input int exp_lat);
    int lat;
    int guard;
    lat   = 1;
    guard = 0;
    @(negedge aclk);
    while (!m_valid_u && guard < 50) begin
      @(posedge aclk);
      lat++;
      guard++;
      @(negedge aclk);
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("s_valid_with_u", {63'b0, m_valid_s}, 64'd1);
  endtask

  initial begin
    int guard;
    // Reset state.
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_m_valid_u", {63'b0, m_valid_u}, 64'd0);
    check("rst_m_valid_s", {63'b0, m_valid_s}, 64'd0);
    check("rst_s_ready_u", {63'b0, s_ready_u}, 64'd0);
    check("rst_s_ready_s", {63'b0, s_ready_s}, 64'd0);
    check("rst_m_count_u", {48'b0, m_count_u}, 64'd0);
    @(posedge aclk);
    #1 aresetn = 1'b1;

    // 1+2+3.
    push(64'd6, 64'd6, 16'd3);
    send_beat(32'd1, 1'b1, 1'b0);
    send_beat(32'd2, 1'b0, 1'b0);
    send_beat(32'd3, 1'b0, 1'b1);
    measure_latency(2);
    wait_drain();

    // Carry across the unit boundary needs one flush cycle.
    push(64'h0000_0001_0000_0000, 64'd0, 16'd2);
    send_beat(32'hFFFF_FFFF, 1'b1, 1'b0);
    send_beat(32'd1, 1'b0, 1'b1);
    measure_latency(3);
    wait_drain();

    // 5 + (-7).
    push(64'h0000_0000_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 16'd2);
    send_beat(32'd5, 1'b1, 1'b0);
    send_beat(32'hFFFF_FFF9, 1'b0, 1'b1);
    wait_drain();

    // Output backpressure: result held stable, input stalled.
    m_ready = 1'b0;
    push(64'd16, 64'd16, 16'd2);
    send_beat(32'd7, 1'b1, 1'b0);
    send_beat(32'd9, 1'b0, 1'b1);
    guard = 0;
    @(negedge aclk);
    while (!m_valid_u && guard < 50) begin
      guard++;
      @(negedge aclk);
    end
    if (!m_valid_u) timeout_fail("bp_wait_valid");
    s_valid = 1'b1;
    s_data  = 32'd99;
    for (int i = 0; i < 10; i++) begin
      check("bp_m_data", m_data_u, 64'd16);
      check("bp_m_count", {48'b0, m_count_u}, 64'd2);
      check("bp_s_ready", {63'b0, s_ready_u}, 64'd0);
      check("bp_m_valid", {63'b0, m_valid_u}, 64'd1);
      @(negedge aclk);
    end
    @(posedge aclk);
    #1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    wait_drain();
    @(negedge aclk);
    check("bp_valid_drop", {63'b0, m_valid_u}, 64'd0);
    @(posedge aclk);
    #1;

    // Mid-frame restart via s_first.
    push(64'd15, 64'd15, 16'd2);
    send_beat(32'd10, 1'b1, 1'b0);
    send_beat(32'd20, 1'b0, 1'b0);
    send_beat(32'd7, 1'b1, 1'b0);
    send_beat(32'd8, 1'b0, 1'b1);
    wait_drain();

    // Reset mid-frame discards the partial frame.
    send_beat(32'd10, 1'b1, 1'b0);
    send_beat(32'd20, 1'b0, 1'b0);
    aresetn = 1'b0;
    @(negedge aclk);
    check("midrst_m_valid", {63'b0, m_valid_u}, 64'd0);
    check("midrst_s_ready", {63'b0, s_ready_u}, 64'd0);
    check("midrst_m_count", {48'b0, m_count_u}, 64'd0);
    @(posedge aclk);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    push(64'd4, 64'd4, 16'd1);
    send_beat(32'd4, 1'b1, 1'b1);
    wait_drain();
    repeat (5) @(posedge aclk);
    #1;

    // Same frames with a randomly toggling clock enable.
    toggle_en = 1'b1;
    push(64'd6, 64'd6, 16'd3);
    send_beat(32'd1, 1'b1, 1'b0);
    send_beat(32'd2, 1'b0, 1'b0);
    send_beat(32'd3, 1'b0, 1'b1);
    wait_drain();
    push(64'h0000_0001_0000_0000, 64'd0, 16'd2);
    send_beat(32'hFFFF_FFFF, 1'b1, 1'b0);
    send_beat(32'd1, 1'b0, 1'b1);
    wait_drain();
    push(64'd15, 64'd15, 16'd2);
    send_beat(32'd10, 1'b1, 1'b0);
    send_beat(32'd20, 1'b0, 1'b0);
    send_beat(32'd7, 1'b1, 1'b0);
    send_beat(32'd8, 1'b0, 1'b1);
    wait_drain();
    toggle_en = 1'b0;

    repeat (10) @(posedge aclk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jelly_integer_accumulator_stream.md
JELLY_INTEGER_ACCUMULATOR_STREAM -- requirements
Module: jelly_integer_accumulator_stream

Interface
REQ-001 SHALL have parameter SIGNED, default 0; when 1, s_data is sign-extended to accumulator width.
REQ-002 SHALL have parameter ACCUMULATOR_WIDTH, default 64; width of the sum.
REQ-003 SHALL have parameter DATA_WIDTH, default 32; input sample width, at most ACCUMULATOR_WIDTH.
REQ-004 SHALL have parameter UNIT_WIDTH, default 32; carry-chain segment width of the accumulator.
REQ-005 SHALL have parameter COUNT_WIDTH, default 16; width of the beat counter.
REQ-006 SHALL have port aresetn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port aclk, input, 1, the single clock.
REQ-008 SHALL have port aclken, input, 1, clock enable; when low, all state and the sub-module are frozen.
REQ-009 SHALL have port s_first, input, 1, start-of-frame flag.
REQ-010 SHALL have port s_last, input, 1, end-of-frame flag.
REQ-011 SHALL have port s_data, input, DATA_WIDTH, sample.
REQ-012 SHALL have port s_valid, input, 1, and port s_ready, output, 1, forming the input handshake.
REQ-013 SHALL have port m_data, output, ACCUMULATOR_WIDTH, frame sum.
REQ-014 SHALL have port m_count, output, COUNT_WIDTH, number of beats summed.
REQ-015 SHALL have port m_valid, output, 1, and port m_ready, input, 1, forming the output handshake.

Function
REQ-016 SHALL implement FSM states IDLE, ACC, FLUSH and OUT; a beat is accepted when s_valid, s_ready and aclken are all high.
REQ-017 SHALL drive s_ready high only in IDLE and ACC while aclken is high.
REQ-018 SHALL issue a sub-module set with count=1 on a beat accepted in IDLE (s_first is ignored there), and move to ACC.
REQ-019 SHALL, for a beat accepted in ACC, issue set with count=1 if s_first is high (frame restart), else issue add with count+1, the counter wrapping modulo 2^COUNT_WIDTH.
REQ-020 SHALL move to FLUSH on any accepted beat with s_last high, including a single beat carrying both s_first and s_last.
REQ-021 SHALL, in FLUSH, each aclken cycle, sample sub-module busy: if high, pulse sub-module cke with set=add=0 so carries propagate one unit; if low, move to OUT.
REQ-022 SHALL, in OUT, hold m_valid high with m_data equal to the sub-module accumulator and m_count equal to the counter, both stable until m_ready is sampled high with aclken, then return to IDLE.
REQ-023 SHALL give m_valid a minimum latency of 2 aclken cycles after the s_last handshake, plus one cycle per pending carry unit (at most UNIT_NUM-1 extra).
REQ-024 SHALL drive sub-module cke = aclken & (beat accepted | state==FLUSH); the sub-module SHALL receive no cke in IDLE or OUT.
REQ-025 SHALL compute the sum modulo 2^ACCUMULATOR_WIDTH; overflow is silent.
REQ-026 SHALL not accept new input in FLUSH or OUT (s_ready low), so backpressure on m_ready stalls the input.

Reset
REQ-027 SHALL, while aresetn is low, force state=IDLE, count=0, m_valid=0 and s_ready=0, asynchronously.
REQ-028 SHALL drive the sub-module synchronous reset from the inverted aresetn; the accumulator value after reset is don't-care because every frame begins with set.
REQ-029 SHALL discard any partial frame or pending output on reset mid-operation, with no output beat produced for it.

Structure
REQ-030 SHALL keep FSM encodings as module-local localparams; no shared package is required.
REQ-031 SHALL instantiate exactly one jelly_integer_accumulator (parameters SIGEND=SIGNED, ACCUMULATOR_WIDTH, DATA_WIDTH, UNIT_WIDTH) as its sub-module.

Verification (ACCUMULATOR_WIDTH=64, UNIT_WIDTH=32, DATA_WIDTH=32 unless stated)
REQ-032 SHALL cover: beats 1, 2, 3 (last on 3), m_ready=1 -> m_data=6, m_count=3, one m_valid beat.
REQ-033 SHALL cover: beats 0xFFFFFFFF then 1 (last) -> m_data=0x0000_0001_0000_0000; m_valid exactly 3 cycles after the last handshake (one flush cycle).
REQ-034 SHALL cover: SIGNED=1, beats 5 then -7 (0xFFFFFFF9) -> m_data=0xFFFF_FFFF_FFFF_FFFE, m_count=2.
REQ-035 SHALL cover: m_ready held low 10 cycles in OUT -> m_data/m_count stable, s_ready=0 throughout, single transfer when m_ready rises.
REQ-036 SHALL cover: beats 10, 20, then 7 with s_first, then 8 with s_last -> m_data=15, m_count=2.
REQ-037 SHALL cover: aresetn pulsed low mid-frame after 10, 20, then frame 4 (last) -> no output for the aborted frame; next m_data=4, m_count=1; aclken toggling on any scenario does not change results.
